// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks register-file read port 3 and streams (addr,data) words; optional checksum word under REGDUMP_CHECKSUM_EN
module regfile_dump #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic [AW-1:0] o_ra,
  input  logic [DW-1:0] i_rd,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [AW-1:0] o_out_addr,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_CSUM,
    S_FIN
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_cnt;
  logic          r_out_valid;
  logic [AW-1:0] r_out_addr;
  logic [DW-1:0] r_out_data;
  logic          r_out_last;
  logic          w_hs;
  logic          w_at_last;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0] r_acc;
`endif

  assign w_hs      = r_out_valid & i_out_ready;
  assign w_at_last = (r_cnt == LAST_IDX);

  assign o_ra        = r_cnt;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_FIN);
  assign o_out_valid = r_out_valid;
  assign o_out_addr  = r_out_addr;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: one READ cycle per word, then wait in SEND for the consumer
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_READ;
        end
      end
      S_READ: w_next = S_SEND;
      S_SEND: begin
        if (w_hs) begin
          if (w_at_last) begin
`ifdef REGDUMP_CHECKSUM_EN
            w_next = S_CSUM;
`else
            w_next = S_FIN;
`endif
          end else begin
            w_next = S_READ;
          end
        end
      end
      S_CSUM: begin
        if (w_hs) begin
          w_next = S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture the read port in READ, hold the word until it is accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      r_acc       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cnt <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            r_acc <= '0;
`endif
          end
        end
        S_READ: begin
          r_out_data  <= i_rd;
          r_out_addr  <= r_cnt;
          r_out_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          // The checksum word carries the last flag instead
          r_out_last  <= 1'b0;
          r_acc       <= r_acc ^ i_rd;
`else
          r_out_last  <= w_at_last;
`endif
        end
        S_SEND: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            if (!w_at_last) begin
              r_cnt <= r_cnt + 1'b1;
            end
`ifdef REGDUMP_CHECKSUM_EN
            else begin
              // Accumulator already holds the final register's contribution
              r_out_valid <= 1'b1;
              r_out_addr  <= '0;
              r_out_data  <= r_acc;
              r_out_last  <= 1'b1;
            end
`endif
          end
        end
        S_CSUM: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
          end
        end
        S_FIN:   r_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule
